// File: rtl/load_store_unit.sv
// RV32I load/store unit: captures one memory op, runs a req/gnt then rvalid bus handshake,
// and returns an extended load result or an error with a one-cycle done pulse.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        is_store_q, is_store_d;
    logic        err_q, err_d;

    function automatic logic access_bad(input logic st, input logic [2:0] f3, input logic [1:0] a);
        logic illegal;
        logic misaligned;
        illegal    = (f3[1:0] == 2'b11) | (st ? f3[2] : (f3 == 3'b110));
        misaligned = ((f3[1:0] == 2'b01) & a[0]) | ((f3[1:0] == 2'b10) & (a != 2'b00));
        return illegal | misaligned;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        res;
        b = word[{a, 3'b000} +: 8];
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            3'b010:  res = word;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] s;
        case (f3)
            3'b000:  s = 4'b0001 << a;
            3'b001:  s = a[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] d;
        case (f3)
            3'b000:  d = {4{w[7:0]}};
            3'b001:  d = {2{w[15:0]}};
            default: d = w;
        endcase
        return d;
    endfunction

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        funct3_d   = funct3_q;
        is_store_d = is_store_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d     = addr;
                    wdata_d    = wdata;
                    funct3_d   = funct3;
                    is_store_d = is_store;
                    err_d      = access_bad(is_store, funct3, addr[1:0]);
                    rdata_d    = 32'd0;
                    state_d    = access_bad(is_store, funct3, addr[1:0]) ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_gnt) state_d = WAIT;
            end
            WAIT: begin
                // Extension is done at capture so RESP only has to gate the register.
                if (mem_rvalid) begin
                    state_d = RESP;
                    rdata_d = is_store_q ? 32'd0 : load_extend(funct3_q, addr_q[1:0], mem_rdata);
                end
            end
            RESP: begin
                state_d = IDLE;
                err_d   = 1'b0;
                rdata_d = 32'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            funct3_q   <= 3'd0;
            is_store_q <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            funct3_q   <= funct3_d;
            is_store_q <= is_store_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == RESP);
    assign err       = done & err_q;
    assign rdata     = done ? rdata_q : 32'd0;
    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req & is_store_q;
    assign mem_wstrb = mem_we ? store_strb(funct3_q, addr_q[1:0]) : 4'b0000;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = store_data(funct3_q, wdata_q);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, errors, bus stalls and reset aborts.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset, start, is_store, mem_gnt, mem_rvalid;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, mem_rdata;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; is_store = 0; funct3 = 3'b000; addr = 0; wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        step(); step();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if ({done, err, mem_req, mem_we} !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b exp 0000", {done, err, mem_req, mem_we}); end
        tests++; if (rdata !== 32'd0) begin fails++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        tests++; if ({mem_addr, mem_wdata, mem_wstrb} !== 68'd0) begin fails++; $display("FAIL reset_bus got %h %h %b exp 0", mem_addr, mem_wdata, mem_wstrb); end
        reset = 0;
        step();
    endtask

    task automatic test_lw();
        start = 1; is_store = 0; funct3 = 3'b010; addr = 32'h100;
        step();                                   // cycle N+1: REQ
        start = 0; addr = 32'hFFFF_FFFC;
        tests++; if ({busy, mem_req, mem_we} !== 3'b110) begin fails++; $display("FAIL lw_req got %b exp 110", {busy, mem_req, mem_we}); end
        tests++; if (mem_addr !== 32'h100) begin fails++; $display("FAIL lw_addr got %h exp 00000100", mem_addr); end
        tests++; if (mem_wstrb !== 4'b0000) begin fails++; $display("FAIL lw_strb got %b exp 0000", mem_wstrb); end
        mem_gnt = 1;
        step();                                   // N+2: WAIT
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        tests++; if ({mem_req, done} !== 2'b00) begin fails++; $display("FAIL lw_wait got %b exp 00", {mem_req, done}); end
        step();                                   // N+3: RESP
        mem_rvalid = 0; mem_rdata = 0;
        tests++; if ({done, err} !== 2'b10) begin fails++; $display("FAIL lw_done got %b exp 10", {done, err}); end
        tests++; if (rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_rdata got %h exp deadbeef", rdata); end
        step();
        tests++; if ({busy, done, rdata} !== 34'd0) begin fails++; $display("FAIL lw_after got busy=%b done=%b rdata=%h exp 0", busy, done, rdata); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3_t  [6] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b100};
        logic [31:0] adr_t [6] = '{32'h203, 32'h203, 32'h202, 32'h202, 32'h202, 32'h201};
        logic [31:0] exp_t [6] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF,
                                   32'hFFFF80FF, 32'hFFFFFFFF, 32'h00000000};
        for (int i = 0; i < 6; i++) begin
            start = 1; is_store = 0; funct3 = f3_t[i]; addr = adr_t[i];
            step();
            start = 0; mem_gnt = 1;
            tests++; if (mem_addr !== 32'h200) begin fails++; $display("FAIL ext%0d_addr got %h exp 00000200", i, mem_addr); end
            step();
            mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h80FF_0000;
            step();
            mem_rvalid = 0; mem_rdata = 0;
            tests++; if ({done, err, rdata} !== {2'b10, exp_t[i]}) begin fails++; $display("FAIL ext%0d got done=%b err=%b rdata=%h exp 1 0 %h", i, done, err, rdata, exp_t[i]); end
            step();
        end
    endtask

    task automatic test_store();
        logic [2:0]  f3_t  [3] = '{3'b000, 3'b001, 3'b010};
        logic [31:0] adr_t [3] = '{32'h6, 32'h6, 32'h8};
        logic [31:0] ma_t  [3] = '{32'h4, 32'h4, 32'h8};
        logic [3:0]  stb_t [3] = '{4'b0100, 4'b1100, 4'b1111};
        logic [31:0] wd_t  [3] = '{32'h78787878, 32'h56785678, 32'h12345678};
        for (int i = 0; i < 3; i++) begin
            start = 1; is_store = 1; funct3 = f3_t[i]; addr = adr_t[i]; wdata = 32'h12345678;
            step();
            start = 0; wdata = 0; is_store = 0; mem_gnt = 1;
            tests++; if ({mem_req, mem_we, mem_wstrb} !== {2'b11, stb_t[i]}) begin fails++; $display("FAIL st%0d_strb got req=%b we=%b strb=%b exp 1 1 %b", i, mem_req, mem_we, mem_wstrb, stb_t[i]); end
            tests++; if ({mem_addr, mem_wdata} !== {ma_t[i], wd_t[i]}) begin fails++; $display("FAIL st%0d_data got %h %h exp %h %h", i, mem_addr, mem_wdata, ma_t[i], wd_t[i]); end
            step();
            mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
            tests++; if ({mem_we, mem_wstrb} !== 5'd0) begin fails++; $display("FAIL st%0d_wait got we=%b strb=%b exp 0", i, mem_we, mem_wstrb); end
            step();
            mem_rvalid = 0; mem_rdata = 0;
            tests++; if ({done, err, rdata} !== {2'b10, 32'd0}) begin fails++; $display("FAIL st%0d_done got done=%b err=%b rdata=%h exp 1 0 0", i, done, err, rdata); end
            step();
        end
    endtask

    task automatic test_error();
        logic        st_t  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3_t  [4] = '{3'b010, 3'b011, 3'b100, 3'b101};
        logic [31:0] adr_t [4] = '{32'h102, 32'h100, 32'h100, 32'h101};
        for (int i = 0; i < 4; i++) begin
            start = 1; is_store = st_t[i]; funct3 = f3_t[i]; addr = adr_t[i]; wdata = 32'hA5A5A5A5;
            mem_rdata = 32'h1234_5678;
            step();                               // N+1
            start = 0;
            tests++; if ({done, err, mem_req, mem_we} !== 4'b1100) begin fails++; $display("FAIL err%0d got done=%b err=%b req=%b we=%b exp 1 1 0 0", i, done, err, mem_req, mem_we); end
            tests++; if (rdata !== 32'd0) begin fails++; $display("FAIL err%0d_rdata got %h exp 0", i, rdata); end
            step();
            mem_rdata = 0;
            tests++; if ({busy, done, err, mem_req} !== 4'b0000) begin fails++; $display("FAIL err%0d_after got %b exp 0000", i, {busy, done, err, mem_req}); end
        end
    endtask

    task automatic test_back_to_back_stall();
        int done_cnt = 0;
        start = 1; is_store = 0; funct3 = 3'b010; addr = 32'h300;
        step();
        for (int i = 0; i < 6; i++) begin
            start = i[0]; addr = 32'hFFF0; mem_rvalid = (i == 0); mem_gnt = (i == 5);
            tests++; if ({mem_req, mem_addr} !== {1'b1, 32'h300}) begin fails++; $display("FAIL stall_req%0d got req=%b addr=%h exp 1 00000300", i, mem_req, mem_addr); end
            if (done) done_cnt++;
            step();
        end
        for (int j = 0; j < 5; j++) begin
            start = j[0]; mem_gnt = 0; mem_rvalid = (j == 4); mem_rdata = 32'h11223344;
            tests++; if ({busy, mem_req} !== 2'b10) begin fails++; $display("FAIL stall_wait%0d got busy=%b req=%b exp 1 0", j, busy, mem_req); end
            if (done) done_cnt++;
            step();
        end
        mem_rvalid = 0; mem_rdata = 0;
        start = 1; addr = 32'h500;                // start during RESP must be ignored
        if (done) done_cnt++;
        tests++; if (rdata !== 32'h11223344) begin fails++; $display("FAIL stall_rdata got %h exp 11223344", rdata); end
        step();
        start = 0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stall_resp_start got busy=%b exp 0", busy); end
        for (int k = 0; k < 3; k++) begin
            if (done) done_cnt++;
            step();
        end
        tests++; if (done_cnt !== 1) begin fails++; $display("FAIL stall_done_count got %0d exp 1", done_cnt); end
    endtask

    task automatic test_reset_abort();
        start = 1; is_store = 0; funct3 = 3'b010; addr = 32'h180;
        step();
        start = 0; mem_gnt = 1;
        step();                                   // WAIT
        mem_gnt = 0; reset = 1;
        step();
        reset = 0;
        tests++; if ({busy, done, mem_req} !== 3'b000) begin fails++; $display("FAIL abort_state got %b exp 000", {busy, done, mem_req}); end
        mem_rvalid = 1; mem_rdata = 32'h0BAD_0BAD;
        step();
        mem_rvalid = 0; mem_rdata = 0;
        tests++; if ({busy, done, rdata} !== 34'd0) begin fails++; $display("FAIL abort_stray got busy=%b done=%b rdata=%h exp 0", busy, done, rdata); end
        reset = 1; start = 1; addr = 32'h40;      // reset wins over start
        step();
        reset = 0; start = 0;
        tests++; if ({busy, mem_addr} !== 33'd0) begin fails++; $display("FAIL reset_prio got busy=%b addr=%h exp 0 0", busy, mem_addr); end
        start = 1; funct3 = 3'b010; addr = 32'h44;
        step();
        start = 0; mem_gnt = 1;
        tests++; if ({mem_req, mem_addr} !== {1'b1, 32'h44}) begin fails++; $display("FAIL post_reset_req got req=%b addr=%h exp 1 00000044", mem_req, mem_addr); end
        step();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
        step();
        mem_rvalid = 0; mem_rdata = 0;
        tests++; if ({done, err, rdata} !== {2'b10, 32'hCAFEF00D}) begin fails++; $display("FAIL post_reset_done got done=%b err=%b rdata=%h exp 1 0 cafef00d", done, err, rdata); end
        step();
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_ext();
        test_store();
        test_error();
        test_back_to_back_stall();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
